johnson_decoder: RTL and testbench

JOHNSON_DECODER -- requirements
Module: johnson_decoder

---
 rtl/johnson_decoder_pkg.sv | 19 +
 rtl/johnson_decoder_if.sv | 42 ++++
 rtl/johnson_code_check.sv | 41 ++++
 rtl/johnson_decoder.sv | 106 ++++++++++
 tb/tb_johnson_decoder.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/johnson_decoder_pkg.sv
// Shared definitions for the Johnson-code decoder: FSM states, default width,
// and the helper that sizes the decoded index.
package johnson_decoder_pkg;

    localparam int unsigned DefaultN    = 4;
    localparam int unsigned DefaultErrW = 8;

    typedef logic [1:0] state_t;

    localparam state_t StUnlocked = 2'd0;
    localparam state_t StAcquire  = 2'd1;
    localparam state_t StLocked   = 2'd2;

    // Width needed to hold any of the 2N legal Johnson indices.
    function automatic int unsigned idx_width(input int unsigned n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/johnson_decoder_if.sv
// Sample/result bundle between a Johnson-counter observer and the decoder.
interface johnson_decoder_if
    import johnson_decoder_pkg::*;
#(
    parameter int unsigned N     = DefaultN,
    parameter int unsigned ERR_W = DefaultErrW
);

    localparam int unsigned IdxW = idx_width(N);

    logic             en;
    logic [N-1:0]     q_in;
    logic             valid;
    logic [IdxW-1:0]  idx;
    logic             illegal;
    logic             seq_err;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output en,
        output q_in,
        input  valid,
        input  idx,
        input  illegal,
        input  seq_err,
        input  locked,
        input  err_cnt
    );

    modport slave (
        input  en,
        input  q_in,
        output valid,
        output idx,
        output illegal,
        output seq_err,
        output locked,
        output err_cnt
    );

endinterface

// File: rtl/johnson_code_check.sv
// Combinational legality check and index decode of one Johnson-coded word.
module johnson_code_check
    import johnson_decoder_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic [N-1:0]           code_i,
    output logic                   legal_o,
    output logic [idx_width(N)-1:0] idx_o
);

    localparam int unsigned IdxW = idx_width(N);
    localparam int unsigned TwoN = 2 * N;
    localparam logic [N-1:0] OneN = N'(1);

    logic [N-1:0]  thermo;
    logic [IdxW:0] ones;
    logic [IdxW:0] two_n;

    assign two_n = TwoN[IdxW:0];

    always_comb begin
        // Fold the upper half onto the lower one: both must become 0..01..1.
        thermo  = code_i[N-1] ? ~code_i : code_i;
        legal_o = ((thermo & (thermo + OneN)) == '0);

        ones = '0;
        for (int i = 0; i < N; i++) begin
            ones = ones + {{IdxW{1'b0}}, code_i[i]};
        end

        if (!legal_o) begin
            idx_o = '0;
        end else if (code_i[N-1]) begin
            idx_o = IdxW'(two_n - ones);
        end else begin
            idx_o = ones[IdxW-1:0];
        end
    end

endmodule

// File: rtl/johnson_decoder.sv
// Decodes sampled Johnson-counter words, tracks sequence lock and counts
// illegal or out-of-sequence samples with a saturating counter.
module johnson_decoder
    import johnson_decoder_pkg::*;
#(
    parameter int unsigned N     = DefaultN,
    parameter int unsigned ERR_W = DefaultErrW
) (
    input logic               clk,
    input logic               rst,
    johnson_decoder_if.slave  bus
);

    localparam int unsigned IdxW = idx_width(N);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(2 * N - 1);

    logic            code_legal;
    logic [IdxW-1:0] code_idx;

    johnson_code_check #(
        .N (N)
    ) u_code_check (
        .code_i  (bus.q_in),
        .legal_o (code_legal),
        .idx_o   (code_idx)
    );

    state_t           state_q,    state_d;
    logic [IdxW-1:0]  prev_idx_q, prev_idx_d;
    logic             valid_q,    valid_d;
    logic [IdxW-1:0]  idx_q,      idx_d;
    logic             illegal_q,  illegal_d;
    logic             seq_err_q,  seq_err_d;
    logic [ERR_W-1:0] err_cnt_q,  err_cnt_d;

    logic [IdxW-1:0] exp_idx;
    logic            err_event;

    assign exp_idx = (prev_idx_q == LastIdx) ? '0 : prev_idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        prev_idx_d = prev_idx_q;
        valid_d    = bus.en;
        idx_d      = idx_q;
        illegal_d  = illegal_q;
        seq_err_d  = 1'b0;
        err_event  = 1'b0;

        if (bus.en) begin
            idx_d     = code_idx;
            illegal_d = ~code_legal;
            if (!code_legal) begin
                state_d   = StUnlocked;
                err_event = 1'b1;
            end else begin
                prev_idx_d = code_idx;
                case (state_q)
                    StUnlocked: state_d = StAcquire;
                    StAcquire:  state_d = (code_idx == exp_idx) ? StLocked : StAcquire;
                    StLocked: begin
                        if (code_idx != exp_idx) begin
                            seq_err_d = 1'b1;
                            err_event = 1'b1;
                            state_d   = StAcquire;
                        end
                    end
                    default:    state_d = StUnlocked;
                endcase
            end
        end

        err_cnt_d = err_cnt_q;
        if (err_event && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StUnlocked;
            prev_idx_q <= '0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            illegal_q  <= 1'b0;
            seq_err_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            prev_idx_q <= prev_idx_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            illegal_q  <= illegal_d;
            seq_err_q  <= seq_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.valid   = valid_q;
    assign bus.idx     = idx_q;
    assign bus.illegal = illegal_q;
    assign bus.seq_err = seq_err_q;
    assign bus.locked  = (state_q == StLocked);
    assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Randomised plus directed bench for johnson_decoder against a table-driven model.
module tb_johnson_decoder;

    localparam int N    = 4;
    localparam int TWON = 2 * N;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    johnson_decoder_if #(.N(N), .ERR_W(8)) bus_a ();
    johnson_decoder_if #(.N(N), .ERR_W(2)) bus_b ();

    johnson_decoder #(.N(N), .ERR_W(8)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    johnson_decoder #(.N(N), .ERR_W(2)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int n_vec;
    int n_err;

    // Reference: the 2N codes a live Johnson counter walks through, by index.
    int codes [TWON];

    int m_state;  // 0 unlocked, 1 acquire, 2 locked
    int m_prev, m_valid, m_idx, m_ill, m_seq, m_err8, m_err2;
    int live_k;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lookup(input int q);
        for (int k = 0; k < TWON; k++) if (codes[k] == q) return k;
        return -1;
    endfunction

    task automatic model_step(input int r, input int e, input int q);
        int k;
        if (r != 0) begin
            m_state = 0; m_prev = 0; m_valid = 0; m_idx = 0;
            m_ill = 0; m_seq = 0; m_err8 = 0; m_err2 = 0;
            return;
        end
        m_valid = e;
        m_seq   = 0;
        if (e == 0) return;
        k = lookup(q);
        if (k < 0) begin
            m_idx = 0; m_ill = 1; m_state = 0;
            m_err8 = (m_err8 < 255) ? m_err8 + 1 : 255;
            m_err2 = (m_err2 < 3) ? m_err2 + 1 : 3;
        end else begin
            m_ill = 0;
            m_idx = k;
            if (m_state == 0) m_state = 1;
            else if (k == (m_prev + 1) % TWON) m_state = 2;
            else begin
                if (m_state == 2) begin
                    m_seq  = 1;
                    m_err8 = (m_err8 < 255) ? m_err8 + 1 : 255;
                    m_err2 = (m_err2 < 3) ? m_err2 + 1 : 3;
                end
                m_state = 1;
            end
            m_prev = k;
        end
    endtask

    task automatic cycle(input int r, input int e, input int q);
        rst        = (r != 0);
        bus_a.en   = (e != 0);
        bus_b.en   = (e != 0);
        bus_a.q_in = 4'(q);
        bus_b.q_in = 4'(q);
        @(posedge clk);
        model_step(r, e, q);
        #1;
        check("valid",   int'(bus_a.valid),   m_valid);
        check("idx",     int'(bus_a.idx),     m_idx);
        check("illegal", int'(bus_a.illegal), m_ill);
        check("seq_err", int'(bus_a.seq_err), m_seq);
        check("locked",  int'(bus_a.locked),  (m_state == 2) ? 1 : 0);
        check("err_cnt", int'(bus_a.err_cnt), m_err8);
        check("err_cnt_w2", int'(bus_b.err_cnt), m_err2);
        check("locked_w2",  int'(bus_b.locked),  (m_state == 2) ? 1 : 0);
    endtask

    // Feed the next code of the live counter.
    task automatic live(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            cycle(0, 1, codes[live_k]);
            live_k = (live_k + 1) % TWON;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int k = 0; k < TWON; k++) begin
            if (k <= N) codes[k] = (1 << k) - 1;
            else        codes[k] = ((1 << N) - 1) ^ ((1 << (k - N)) - 1);
        end
        rst = 1'b1;
        bus_a.en = 1'b0; bus_a.q_in = '0;
        bus_b.en = 1'b0; bus_b.q_in = '0;

        // Reset state, then a live counter through one full wrap.
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        live_k = 0;
        live(9);
        check("lock_after_wrap", int'(bus_a.locked), 1);

        // Illegal injection while locked, then reacquire on 1110, 1100.
        cycle(0, 1, 4'b0101);
        check("illegal_flag", int'(bus_a.illegal), 1);
        cycle(0, 1, 4'b1110);
        cycle(0, 1, 4'b1100);
        check("relock", int'(bus_a.locked), 1);

        // Walk to idx 3, then jump to idx 5 for a sequence error.
        live_k = 7;
        live(5);
        cycle(0, 1, 4'b1110);
        check("seq_err_flag", int'(bus_a.seq_err), 1);
        cycle(0, 1, 4'b1100);

        // Idle gap, then resume on the expected code.
        for (int i = 0; i < 5; i++) cycle(0, 0, $urandom_range(0, 15));
        live_k = 7;
        live(3);

        // Reset collides with a legal sample while locked.
        cycle(1, 1, codes[live_k]);
        check("rst_priority_locked", int'(bus_a.locked), 0);
        live(2);

        // Saturation on the narrow counter: five illegal samples.
        cycle(1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 4'b1010);
        check("sat_w2", int'(bus_b.err_cnt), 3);

        // Random mix: mostly a live counter with glitches, gaps and resets.
        cycle(1, 0, 0);
        live_k = $urandom_range(0, TWON - 1);
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 2)       cycle(1, $urandom_range(0, 1), codes[live_k]);
            else if (sel < 12) cycle(0, 0, $urandom_range(0, 15));
            else if (sel < 22) cycle(0, 1, $urandom_range(0, 15));
            else if (sel < 27) begin
                live_k = $urandom_range(0, TWON - 1);
                live(1);
            end else           live(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
